regfile: RTL and testbench
==========================

Name: regfile

Overview:
- Integer register file for the simple CPU: the reader side of the architectural state that the writeback stage updates.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Same-cycle write-to-read bypass.
- Per-register pending-write scoreboard so decode can detect RAW hazards against multi-cycle producers (loads) and raise a stall.

Parameters:
- DATAWIDTH, 32, width of each register and data port.
- NREGS, 32, number of architectural registers (power of two).
- ADDRWIDTH, 5, register index width; must equal clog2(NREGS).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- rs1_addr_i  input  ADDRWIDTH  read port 1 index.
- rs1_used_i  input  1  current instruction consumes rs1.
- rs1_data_o  output  DATAWIDTH  read port 1 data.
- rs2_addr_i  input  ADDRWIDTH  read port 2 index.
- rs2_used_i  input  1  current instruction consumes rs2.
- rs2_data_o  output  DATAWIDTH  read port 2 data.
- we_i  input  1  writeback enable.
- rd_addr_i  input  ADDRWIDTH  writeback index.
- rd_data_i  input  DATAWIDTH  writeback data.
- issue_i  input  1  instruction with a deferred result issued this cycle; mark its destination pending.
- issue_addr_i  input  ADDRWIDTH  destination of the issued instruction.
- rs1_busy_o  output  1  rs1 has an unresolved pending write.
- rs2_busy_o  output  1  rs2 has an unresolved pending write.
- stall_o  output  1  RAW hazard; decode must hold.

Behaviour:
- Reset (async, immediate):
  - All NREGS entries cleared to 0 and all busy bits cleared.
  - While rst_i is high: rs*_data_o = 0, rs*_busy_o = 0, stall_o = 0.
  - No write or issue takes effect while rst_i is high, nor on the edge where it deasserts.
- Register x0:
  - Reads always return 0.
  - Writes to index 0 are ignored.
  - Issue to index 0 never sets busy.
  - Busy bit 0 is constant 0.
- Write:
  - On a rising edge with we_i=1 and rd_addr_i!=0, entry[rd_addr_i] <= rd_data_i.
  - Visible from the array on the next cycle.
- Read: combinational, zero latency.
  - rsN_data_o = 0 if rsN_addr_i==0.
  - Otherwise rd_data_i if (we_i && rd_addr_i==rsN_addr_i), which is the bypass.
  - Otherwise entry[rsN_addr_i].
  - Both ports may read the same index; both receive identical data.
- Scoreboard, per busy bit b[i] at the rising edge:
  - Set if issue_i && issue_addr_i==i && i!=0.
  - Else cleared if we_i && rd_addr_i==i.
  - Else hold.
  - Simultaneous issue and writeback to the same index: set wins (the new producer is still outstanding).
  - Re-issue to an already-busy index: stays busy, with no count. One outstanding deferred write per register is guaranteed by the pipeline.
- Busy outputs: rsN_busy_o = b[rsN_addr_i] && !(we_i && rd_addr_i==rsN_addr_i). The bypass satisfies the hazard in the same cycle.
- Stall: stall_o = (rs1_used_i && rs1_busy_o) || (rs2_used_i && rs2_busy_o). Purely combinational, no registered delay.
- Writes from non-issued (single-cycle) producers to a non-busy index leave busy at 0.
- Width rules: no truncation or extension. Out-of-range indices cannot occur because NREGS == 2**ADDRWIDTH.

Decomposition:
- Package regfile_pkg holds:
  - REG_ADDRWIDTH = 5, REG_NREGS = 32, XLEN = 32.
  - typedef reg_addr_t as logic [REG_ADDRWIDTH-1:0].
  - typedef word_t as logic [XLEN-1:0].
  - Constant REG_ZERO = '0.
- One sub-module, regfile_scoreboard: the NREGS busy bits, set/clear priority, and the busy/stall outputs. It is instantiated once inside regfile.
- The storage array and read/bypass muxing stay in regfile.

Test Plan:
- Reset: assert rst_i mid-run after writing x5=0xDEADBEEF and issuing x7 -> rs1_data_o=0 for x5, rs*_busy_o=0 and stall_o=0 immediately; after deassert, reading x5 returns 0.
- x0: we_i=1, rd=0, data=0x12345678; issue_i=1 to x0 -> read x0 returns 0, rs1_busy_o=0, stall_o=0.
- Write/read and bypass: write x3=0xA5A5A5A5 and in the same cycle read rs1=x3 -> rs1_data_o=0xA5A5A5A5 combinationally; next cycle with we_i=0 -> still 0xA5A5A5A5. Read rs1=rs2=x3 -> both ports equal.
- Load hazard: issue x9, next cycle rs2=x9 with rs2_used_i=1 -> stall_o=1 each cycle until a write of x9=0x00000042. In the write cycle: stall_o=0, rs2_data_o=0x42. Afterwards: busy clear.
- Unused operand: x9 busy, rs1=x9 with rs1_used_i=0 -> rs1_busy_o=1, stall_o=0.
- Simultaneous set/clear: x4 busy; same edge has we_i to x4 and issue_i to x4 -> after the edge rs1_busy_o=1 for x4; a later write clears it to 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizing for the integer register file.
// Every other regfile source file imports this package.
package regfile_pkg;
    localparam int REG_ADDRWIDTH = 5;
    localparam int REG_NREGS     = 32;
    localparam int XLEN          = 32;

    typedef logic [REG_ADDRWIDTH-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]          word_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bundle of the register file.
// The slave modport is the register file; the master modport is the pipeline.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int ADDRWIDTH = REG_ADDRWIDTH,
    parameter int DATAWIDTH = XLEN
);
    logic [ADDRWIDTH-1:0] rs1_addr_i;
    logic                 rs1_used_i;
    logic [DATAWIDTH-1:0] rs1_data_o;
    logic [ADDRWIDTH-1:0] rs2_addr_i;
    logic                 rs2_used_i;
    logic [DATAWIDTH-1:0] rs2_data_o;
    logic                 we_i;
    logic [ADDRWIDTH-1:0] rd_addr_i;
    logic [DATAWIDTH-1:0] rd_data_i;
    logic                 issue_i;
    logic [ADDRWIDTH-1:0] issue_addr_i;
    logic                 rs1_busy_o;
    logic                 rs2_busy_o;
    logic                 stall_o;

    modport slave (
        input  rs1_addr_i, rs1_used_i, rs2_addr_i, rs2_used_i,
        input  we_i, rd_addr_i, rd_data_i, issue_i, issue_addr_i,
        output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, stall_o
    );

    modport master (
        output rs1_addr_i, rs1_used_i, rs2_addr_i, rs2_used_i,
        output we_i, rd_addr_i, rd_data_i, issue_i, issue_addr_i,
        input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, stall_o
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue of a
// deferred producer, cleared by its writeback; drives the decode stall.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS     = REG_NREGS,
    parameter int ADDRWIDTH = REG_ADDRWIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_issue,
    input  logic [ADDRWIDTH-1:0] i_issue_addr,
    input  logic                 i_we,
    input  logic [ADDRWIDTH-1:0] i_rd_addr,
    input  logic [ADDRWIDTH-1:0] i_rs1_addr,
    input  logic                 i_rs1_used,
    input  logic [ADDRWIDTH-1:0] i_rs2_addr,
    input  logic                 i_rs2_used,
    output logic                 o_rs1_busy,
    output logic                 o_rs2_busy,
    output logic                 o_stall
);
    // Bit 0 has no storage: x0 can never be pending.
    logic [NREGS-1:1] r_busy;
    logic [NREGS-1:0] w_busy;
    logic             w_rs1_hit;
    logic             w_rs2_hit;

    assign w_busy = {r_busy, 1'b0};

    // Set beats clear: a writeback retiring the old producer in the same
    // cycle a new producer issues must leave the register pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (i_issue && (i_issue_addr == ADDRWIDTH'(i)))
                    r_busy[i] <= 1'b1;
                else if (i_we && (i_rd_addr == ADDRWIDTH'(i)))
                    r_busy[i] <= 1'b0;
            end
        end
    end

    assign w_rs1_hit  = i_we && (i_rd_addr == i_rs1_addr);
    assign w_rs2_hit  = i_we && (i_rd_addr == i_rs2_addr);

    // A same-cycle writeback is forwarded by the bypass, so it resolves the hazard.
    assign o_rs1_busy = w_busy[i_rs1_addr] && !w_rs1_hit;
    assign o_rs2_busy = w_busy[i_rs2_addr] && !w_rs2_hit;
    assign o_stall    = (i_rs1_used && o_rs1_busy) || (i_rs2_used && o_rs2_busy);
endmodule

// File: rtl/regfile.sv
// Integer register file: two combinational read ports with writeback bypass,
// one synchronous write port, and the RAW-hazard scoreboard.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATAWIDTH = XLEN,
    parameter int NREGS     = REG_NREGS,
    parameter int ADDRWIDTH = REG_ADDRWIDTH
) (
    input  logic     clk_i,
    input  logic     rst_i,
    regfile_if.slave rf
);
    localparam logic [ADDRWIDTH-1:0] ZERO_IDX = ADDRWIDTH'(REG_ZERO);

    logic [NREGS-1:0][DATAWIDTH-1:0] r_mem;
    logic [DATAWIDTH-1:0]            w_rs1_data;
    logic [DATAWIDTH-1:0]            w_rs2_data;
    logic                            w_wr_en;

    assign w_wr_en = rf.we_i && (rf.rd_addr_i != ZERO_IDX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_mem <= '0;
        else if (w_wr_en)
            r_mem[rf.rd_addr_i] <= rf.rd_data_i;
    end

    // Reset also masks the bypass path, which would otherwise leak rd_data_i.
    always_comb begin
        w_rs1_data = r_mem[rf.rs1_addr_i];
        if (rst_i || (rf.rs1_addr_i == ZERO_IDX))
            w_rs1_data = '0;
        else if (rf.we_i && (rf.rd_addr_i == rf.rs1_addr_i))
            w_rs1_data = rf.rd_data_i;
    end

    always_comb begin
        w_rs2_data = r_mem[rf.rs2_addr_i];
        if (rst_i || (rf.rs2_addr_i == ZERO_IDX))
            w_rs2_data = '0;
        else if (rf.we_i && (rf.rd_addr_i == rf.rs2_addr_i))
            w_rs2_data = rf.rd_data_i;
    end

    assign rf.rs1_data_o = w_rs1_data;
    assign rf.rs2_data_o = w_rs2_data;

    regfile_scoreboard #(
        .NREGS     (NREGS),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_sb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_issue      (rf.issue_i),
        .i_issue_addr (rf.issue_addr_i),
        .i_we         (rf.we_i),
        .i_rd_addr    (rf.rd_addr_i),
        .i_rs1_addr   (rf.rs1_addr_i),
        .i_rs1_used   (rf.rs1_used_i),
        .i_rs2_addr   (rf.rs2_addr_i),
        .i_rs2_used   (rf.rs2_used_i),
        .o_rs1_busy   (rf.rs1_busy_o),
        .o_rs2_busy   (rf.rs2_busy_o),
        .o_stall      (rf.stall_o)
    );
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus random traffic
// compared against an array/flag reference model.
module tb_regfile;
    import regfile_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    regfile_if rf ();

    regfile dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rf    (rf)
    );

    word_t m_mem  [REG_NREGS];
    bit    m_busy [REG_NREGS];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word_t m_read(input reg_addr_t a);
        if (rst_i || a == 0) return '0;
        if (rf.we_i && rf.rd_addr_i == a) return rf.rd_data_i;
        return m_mem[a];
    endfunction

    function automatic logic m_bsy(input reg_addr_t a);
        if (rst_i) return 1'b0;
        return m_busy[a] && !(rf.we_i && rf.rd_addr_i == a);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < REG_NREGS; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic b1, b2;
        b1 = m_bsy(rf.rs1_addr_i);
        b2 = m_bsy(rf.rs2_addr_i);
        chk({tag, ".d1"}, rf.rs1_data_o, m_read(rf.rs1_addr_i));
        chk({tag, ".d2"}, rf.rs2_data_o, m_read(rf.rs2_addr_i));
        chk({tag, ".b1"}, 32'(rf.rs1_busy_o), 32'(b1));
        chk({tag, ".b2"}, 32'(rf.rs2_busy_o), 32'(b2));
        chk({tag, ".stall"}, 32'(rf.stall_o),
            32'((rf.rs1_used_i && b1) || (rf.rs2_used_i && b2)));
    endtask

    task automatic model_edge();
        bit nb [REG_NREGS];
        if (rst_i) return;
        for (int i = 0; i < REG_NREGS; i++) begin
            nb[i] = m_busy[i];
            if (rf.issue_i && rf.issue_addr_i == i && i != 0) nb[i] = 1'b1;
            else if (rf.we_i && rf.rd_addr_i == i)            nb[i] = 1'b0;
        end
        for (int i = 0; i < REG_NREGS; i++) m_busy[i] = nb[i];
        if (rf.we_i && rf.rd_addr_i != 0) m_mem[rf.rd_addr_i] = rf.rd_data_i;
    endtask

    task automatic cycle(input string tag);
        check_all(tag);
        model_edge();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive(input logic we, input reg_addr_t rd, input word_t wd,
                         input logic iss, input reg_addr_t ia,
                         input reg_addr_t r1, input logic u1,
                         input reg_addr_t r2, input logic u2);
        rf.we_i = we;  rf.rd_addr_i = rd;  rf.rd_data_i = wd;
        rf.issue_i = iss;  rf.issue_addr_i = ia;
        rf.rs1_addr_i = r1;  rf.rs1_used_i = u1;
        rf.rs2_addr_i = r2;  rf.rs2_used_i = u2;
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        m_reset();
        drive(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1);
        chk("rst.d1", rf.rs1_data_o, 32'h0);
        chk("rst.stall", 32'(rf.stall_o), 32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // x0 is hardwired
        drive(1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        chk("x0.byp", rf.rs1_data_o, 32'h0);
        cycle("x0.w");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        chk("x0.rd", rf.rs1_data_o, 32'h0);
        chk("x0.busy", 32'(rf.rs1_busy_o), 32'h0);
        chk("x0.stall", 32'(rf.stall_o), 32'h0);
        cycle("x0.r");

        // write with same-cycle bypass, then registered read on both ports
        drive(1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0);
        chk("byp.d1", rf.rs1_data_o, 32'hA5A5_A5A5);
        cycle("byp");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1);
        chk("arr.d1", rf.rs1_data_o, 32'hA5A5_A5A5);
        chk("arr.d2", rf.rs2_data_o, 32'hA5A5_A5A5);
        cycle("arr");

        // load hazard on x9
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle("ld.iss");
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1);
            chk("ld.stall", 32'(rf.stall_o), 32'h1);
            cycle("ld.wait");
        end
        drive(1'b1, 5'd9, 32'h0000_0042, 1'b0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1);
        chk("ld.wb.stall", 32'(rf.stall_o), 32'h0);
        chk("ld.wb.d2", rf.rs2_data_o, 32'h0000_0042);
        cycle("ld.wb");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1);
        chk("ld.clr", 32'(rf.rs2_busy_o), 32'h0);
        cycle("ld.after");

        // busy operand that the instruction does not consume
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle("unused.iss");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0);
        chk("unused.b1", 32'(rf.rs1_busy_o), 32'h1);
        chk("unused.stall", 32'(rf.stall_o), 32'h0);
        cycle("unused");

        // simultaneous set and clear on x4
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle("sc.iss");
        drive(1'b1, 5'd4, 32'h0000_0007, 1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle("sc.both");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 1'b1, 5'd0, 1'b0);
        chk("sc.set", 32'(rf.rs1_busy_o), 32'h1);
        cycle("sc.chk");
        drive(1'b1, 5'd4, 32'h0000_0008, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle("sc.wb");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 1'b1, 5'd0, 1'b0);
        chk("sc.clr", 32'(rf.rs1_busy_o), 32'h0);
        chk("sc.data", rf.rs1_data_o, 32'h0000_0008);
        cycle("sc.after");

        // asynchronous reset mid-run
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle("rs.w5");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle("rs.i7");
        drive(1'b1, 5'd5, 32'h0000_0001, 1'b0, 5'd0, 5'd5, 1'b1, 5'd7, 1'b1);
        rst_i = 1'b1;
        #1;
        m_reset();
        chk("rs.d1", rf.rs1_data_o, 32'h0);
        chk("rs.b1", 32'(rf.rs1_busy_o), 32'h0);
        chk("rs.b2", 32'(rf.rs2_busy_o), 32'h0);
        chk("rs.stall", 32'(rf.stall_o), 32'h0);
        cycle("rs.hold");
        rst_i = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd7, 1'b1);
        chk("rs.x5", rf.rs1_data_o, 32'h0);
        chk("rs.x7", 32'(rf.rs2_busy_o), 32'h0);
        cycle("rs.after");

        // random traffic, addresses narrowed to force collisions
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
